// File: rtl/ethernet_mmio_bridge.sv
// ethernet_mmio_bridge: valid/ready MMIO front-end for ethernet_controller.
// Issues one-cycle controller strobes and returns one in-order response per request.
module ethernet_mmio_bridge #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 14,
  parameter int resp_els_p   = 2,
  parameter int rd_timeout_p = 15,
  localparam int max_size_lp   = $clog2(data_width_p / 8),
  localparam int size_width_lp = (max_size_lp == 0) ? 1 : $clog2(max_size_lp + 1)
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     req_v_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [addr_width_p-1:0]  req_addr_i,
  input  logic [size_width_lp-1:0] req_size_i,
  input  logic [data_width_p-1:0]  req_data_i,
  output logic                     resp_v_o,
  input  logic                     resp_yumi_i,
  output logic [data_width_p-1:0]  resp_data_o,
  output logic                     resp_err_o,
  output logic [addr_width_p-1:0]  addr_o,
  output logic                     write_en_o,
  output logic                     read_en_o,
  output logic [size_width_lp-1:0] op_size_o,
  output logic [data_width_p-1:0]  write_data_o,
  input  logic [data_width_p-1:0]  read_data_i,
  input  logic                     read_data_v_i,
  output logic                     stray_rdata_o
);

  localparam int ptr_width_lp = (resp_els_p > 1) ? $clog2(resp_els_p) : 1;
  localparam int cnt_width_lp = $clog2(resp_els_p + 1);
  localparam int tmr_width_lp = (rd_timeout_p > 1) ? $clog2(rd_timeout_p) : 1;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    WAIT_RD = 1'b1
  } state_e;

  state_e                  state_r, state_n;
  logic [tmr_width_lp-1:0] tmr_r;
  logic                    tmr_clr, tmr_inc;
  logic [ptr_width_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [cnt_width_lp-1:0] cnt_r;
  logic                    fifo_empty, fifo_full;
  logic                    enq, deq, enq_err;
  logic [data_width_p-1:0] enq_data;
  logic [addr_width_p-1:0] align_mask;
  logic                    legal, ready, strobe;
  logic                    stray_r;

  logic [data_width_p-1:0] mem_data_r [resp_els_p];
  logic                    mem_err_r  [resp_els_p];

  function automatic logic [ptr_width_lp-1:0] ptr_next(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(resp_els_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  assign fifo_empty = (cnt_r == '0);
  assign fifo_full  = (cnt_r == cnt_width_lp'(resp_els_p));
  assign deq        = resp_yumi_i & ~fifo_empty;

  assign align_mask = (addr_width_p'(1) << req_size_i) - addr_width_p'(1);
  assign legal      = (req_size_i <= size_width_lp'(max_size_lp))
                    && ((req_addr_i & align_mask) == '0);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  // Ready is gated by reset so every handshake output reads 0 while reset is held.
  always_comb begin
    state_n    = state_r;
    ready      = 1'b0;
    write_en_o = 1'b0;
    read_en_o  = 1'b0;
    enq        = 1'b0;
    enq_data   = '0;
    enq_err    = 1'b0;
    tmr_clr    = 1'b0;
    tmr_inc    = 1'b0;
    case (state_r)
      IDLE: begin
        ready = reset_n_i & ~fifo_full;
        if (req_v_i && ready) begin
          if (!legal) begin
            enq     = 1'b1;
            enq_err = 1'b1;
          end else if (req_we_i) begin
            write_en_o = 1'b1;
            enq        = 1'b1;
          end else begin
            read_en_o = 1'b1;
            tmr_clr   = 1'b1;
            state_n   = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (read_data_v_i) begin
          enq      = 1'b1;
          enq_data = read_data_i;
          state_n  = IDLE;
        end else if (tmr_r == tmr_width_lp'(rd_timeout_p - 1)) begin
          enq      = 1'b1;
          enq_data = '1;
          enq_err  = 1'b1;
          state_n  = IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign req_ready_o  = ready;
  assign strobe       = write_en_o | read_en_o;
  assign addr_o       = strobe ? req_addr_i : '0;
  assign op_size_o    = strobe ? req_size_i : '0;
  assign write_data_o = strobe ? req_data_i : '0;

  // tmr_r counts wait cycles already spent, so the timeout fires on the rd_timeout_p-th one.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)   tmr_r <= '0;
    else if (tmr_clr) tmr_r <= '0;
    else if (tmr_inc) tmr_r <= tmr_r + tmr_width_lp'(1);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
    end else begin
      if (enq) wr_ptr_r <= ptr_next(wr_ptr_r);
      if (deq) rd_ptr_r <= ptr_next(rd_ptr_r);
      case ({enq, deq})
        2'b10:   cnt_r <= cnt_r + cnt_width_lp'(1);
        2'b01:   cnt_r <= cnt_r - cnt_width_lp'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq) begin
      mem_data_r[wr_ptr_r] <= enq_data;
      mem_err_r[wr_ptr_r]  <= enq_err;
    end
  end

  assign resp_v_o    = ~fifo_empty;
  assign resp_data_o = fifo_empty ? '0 : mem_data_r[rd_ptr_r];
  assign resp_err_o  = ~fifo_empty & mem_err_r[rd_ptr_r];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)                                  stray_r <= 1'b0;
    else if (read_data_v_i && (state_r != WAIT_RD)) stray_r <= 1'b1;
  end

  assign stray_rdata_o = stray_r;

endmodule

// File: tb/tb_ethernet_mmio_bridge.sv
// tb_ethernet_mmio_bridge: randomized bench with a transaction-level response model,
// a simple controller responder, and hand-computed checks on key scenarios.
module tb_ethernet_mmio_bridge;

  localparam int TMO = 15;
  localparam int ELS = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_v, req_ready, req_we;
  logic [13:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_data;
  logic        resp_v, resp_yumi, resp_err;
  logic [31:0] resp_data;
  logic [13:0] addr_o;
  logic        write_en, read_en;
  logic [1:0]  op_size;
  logic [31:0] write_data, read_data;
  logic        read_data_v, stray;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int          yumi_mode;
  int          pop_credits;
  int          rd_delay;
  logic [31:0] rd_value;
  bit          ctrl_busy;

  int          last_cyc;
  logic        last_wen, last_ren, last_resp_v, last_resp_err;
  logic [13:0] last_addr;
  logic [31:0] last_wdata, last_resp_data;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t exp_q[$];
  bit    m_busy;
  int    m_wait;
  bit    m_stray;

  ethernet_mmio_bridge dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .req_v_i      (req_v),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_addr_i   (req_addr),
    .req_size_i   (req_size),
    .req_data_i   (req_data),
    .resp_v_o     (resp_v),
    .resp_yumi_i  (resp_yumi),
    .resp_data_o  (resp_data),
    .resp_err_o   (resp_err),
    .addr_o       (addr_o),
    .write_en_o   (write_en),
    .read_en_o    (read_en),
    .op_size_o    (op_size),
    .write_data_o (write_data),
    .read_data_i  (read_data),
    .read_data_v_i(read_data_v),
    .stray_rdata_o(stray)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Transaction-level model: one outstanding read, responses queued in request order.
  always @(negedge clk) begin : compare
    bit    exp_ready, acc, legal, was_busy, strobe_exp;
    int    sz, ad;
    resp_t r;
    if (!reset_n) begin
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_resp_v", 32'(resp_v), 32'd0);
      checkOutput("rst_write_en", 32'(write_en), 32'd0);
      checkOutput("rst_read_en", 32'(read_en), 32'd0);
      checkOutput("rst_addr", 32'(addr_o), 32'd0);
      checkOutput("rst_wdata", write_data, 32'd0);
      checkOutput("rst_stray", 32'(stray), 32'd0);
      exp_q.delete();
      m_busy  = 1'b0;
      m_stray = 1'b0;
    end else begin
      sz         = int'(req_size);
      ad         = int'(req_addr);
      legal      = (sz <= 2) && ((ad % (1 << sz)) == 0);
      exp_ready  = !m_busy && (exp_q.size() < ELS);
      acc        = req_v && exp_ready;
      strobe_exp = acc && legal;
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("write_en", 32'(write_en), 32'(strobe_exp && req_we));
      checkOutput("read_en", 32'(read_en), 32'(strobe_exp && !req_we));
      checkOutput("addr_o", 32'(addr_o), strobe_exp ? 32'(req_addr) : 32'd0);
      checkOutput("op_size", 32'(op_size), strobe_exp ? 32'(req_size) : 32'd0);
      checkOutput("write_data", write_data, strobe_exp ? req_data : 32'd0);
      checkOutput("resp_v", 32'(resp_v), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        checkOutput("resp_data", resp_data, exp_q[0].data);
        checkOutput("resp_err", 32'(resp_err), 32'(exp_q[0].err));
      end
      checkOutput("stray", 32'(stray), 32'(m_stray));

      was_busy = m_busy;
      if (resp_yumi && (exp_q.size() != 0)) void'(exp_q.pop_front());
      if (acc) begin
        if (!legal) begin
          r.data = 32'd0; r.err = 1'b1; exp_q.push_back(r);
        end else if (req_we) begin
          r.data = 32'd0; r.err = 1'b0; exp_q.push_back(r);
        end else begin
          m_busy = 1'b1;
          m_wait = 0;
        end
      end
      if (was_busy) begin
        m_wait++;
        if (read_data_v) begin
          r.data = read_data; r.err = 1'b0; exp_q.push_back(r);
          m_busy = 1'b0;
        end else if (m_wait == TMO) begin
          r.data = 32'hFFFF_FFFF; r.err = 1'b1; exp_q.push_back(r);
          m_busy = 1'b0;
        end
      end else if (read_data_v) begin
        m_stray = 1'b1;
      end
    end
  end

  // Controller stand-in: answers a read strobe after rd_delay cycles (0 = never).
  initial begin
    read_data_v = 1'b0;
    read_data   = '0;
    ctrl_busy   = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && read_en && (rd_delay > 0)) begin
        ctrl_busy = 1'b1;
        repeat (rd_delay) @(posedge clk);
        #1;
        read_data_v = 1'b1;
        read_data   = rd_value;
        @(posedge clk);
        #1;
        read_data_v = 1'b0;
        ctrl_busy   = 1'b0;
      end
    end
  end

  // Response consumer: 0 random, 1 always, 2 only when credits are granted.
  initial begin
    resp_yumi = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (yumi_mode)
        0: resp_yumi = resp_v && ($urandom_range(0, 2) != 0);
        1: resp_yumi = resp_v;
        default: begin
          if (resp_v && (pop_credits > 0)) begin
            resp_yumi = 1'b1;
            pop_credits--;
          end else begin
            resp_yumi = 1'b0;
          end
        end
      endcase
    end
  end

  task automatic next_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit we, input logic [13:0] addr, input logic [1:0] size,
                               input logic [31:0] data, input int delay, input logic [31:0] rval);
    bit ok = 1'b0;
    rd_delay = delay;
    rd_value = rval;
    req_v    = 1'b1;
    req_we   = we;
    req_addr = addr;
    req_size = size;
    req_data = data;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok             = 1'b1;
        last_cyc       = cyc;
        last_wen       = write_en;
        last_ren       = read_en;
        last_addr      = addr_o;
        last_wdata     = write_data;
        last_resp_v    = resp_v;
        last_resp_err  = resp_err;
        last_resp_data = resp_data;
        break;
      end
      next_slot();
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL accept_timeout: got no req_ready, expected 1 within 64 cycles");
    end
    next_slot();
    req_v = 1'b0;
  endtask

  task automatic wait_ctrl();
    for (int i = 0; (i < 64) && ctrl_busy; i++) next_slot();
    checkOutput("ctrl_idle", 32'(ctrl_busy), 32'd0);
  endtask

  task automatic wait_resp(output int at_cycle);
    at_cycle = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (resp_v) begin
        at_cycle = cyc;
        break;
      end
    end
  endtask

  initial begin : driver
    int t, t2, rc;
    int sz, mask, sel, dly;
    logic [13:0] a;
    reset_n     = 1'b0;
    req_v       = 1'b0;
    req_we      = 1'b0;
    req_addr    = '0;
    req_size    = '0;
    req_data    = '0;
    yumi_mode   = 1;
    pop_credits = 0;
    rd_delay    = 0;
    rd_value    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    next_slot();

    // Aligned word write.
    applyStimulus(1'b1, 14'h0010, 2'd2, 32'hDEAD_BEEF, 0, 32'h0);
    checkOutput("t1_wen", 32'(last_wen), 32'd1);
    checkOutput("t1_addr", 32'(last_addr), 32'h10);
    checkOutput("t1_wdata", last_wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("t1_resp_v", 32'(resp_v), 32'd1);
    checkOutput("t1_resp_data", resp_data, 32'd0);
    checkOutput("t1_resp_err", 32'(resp_err), 32'd0);
    next_slot();

    // Read answered one cycle after the strobe.
    applyStimulus(1'b0, 14'h0800, 2'd2, 32'h0, 1, 32'h1234_5678);
    checkOutput("t2_ren", 32'(last_ren), 32'd1);
    checkOutput("t2_addr", 32'(last_addr), 32'h800);
    @(negedge clk);
    checkOutput("t2_ready_busy", 32'(req_ready), 32'd0);
    checkOutput("t2_no_resp_yet", 32'(resp_v), 32'd0);
    @(negedge clk);
    checkOutput("t2_resp_v", 32'(resp_v), 32'd1);
    checkOutput("t2_resp_data", resp_data, 32'h1234_5678);
    checkOutput("t2_resp_err", 32'(resp_err), 32'd0);
    wait_ctrl();
    next_slot();

    // Misaligned read, then a request accepted the very next cycle.
    applyStimulus(1'b0, 14'h0002, 2'd2, 32'h0, 1, 32'h0);
    t = last_cyc;
    checkOutput("t3_no_ren", 32'(last_ren), 32'd0);
    checkOutput("t3_no_wen", 32'(last_wen), 32'd0);
    applyStimulus(1'b1, 14'h0020, 2'd0, 32'h0000_00A5, 0, 32'h0);
    checkOutput("t3_next_accept", 32'(last_cyc - t), 32'd1);
    checkOutput("t3_resp_v", 32'(last_resp_v), 32'd1);
    checkOutput("t3_resp_err", 32'(last_resp_err), 32'd1);
    checkOutput("t3_resp_data", last_resp_data, 32'd0);
    next_slot();

    // Lost read times out; the late data marks a stray.
    applyStimulus(1'b0, 14'h0040, 2'd2, 32'h0, 20, 32'h0000_0055);
    t = last_cyc;
    wait_resp(rc);
    checkOutput("t4_timeout_lat", 32'(rc - t), 32'd16);
    checkOutput("t4_resp_data", resp_data, 32'hFFFF_FFFF);
    checkOutput("t4_resp_err", 32'(resp_err), 32'd1);
    checkOutput("t4_stray_before", 32'(stray), 32'd0);
    wait_ctrl();
    @(negedge clk);
    checkOutput("t4_stray_after", 32'(stray), 32'd1);
    next_slot();

    // Data arriving in the timeout cycle wins.
    applyStimulus(1'b0, 14'h0044, 2'd2, 32'h0, 15, 32'h0BAD_CAFE);
    t = last_cyc;
    wait_resp(rc);
    checkOutput("t4b_lat", 32'(rc - t), 32'd16);
    checkOutput("t4b_resp_data", resp_data, 32'h0BAD_CAFE);
    checkOutput("t4b_resp_err", 32'(resp_err), 32'd0);
    wait_ctrl();
    next_slot();

    // FIFO full blocks the third write until one response is consumed.
    yumi_mode = 2;
    applyStimulus(1'b1, 14'h0100, 2'd2, 32'h1111_1111, 0, 32'h0);
    t = last_cyc;
    applyStimulus(1'b1, 14'h0104, 2'd2, 32'h2222_2222, 0, 32'h0);
    checkOutput("t5_second_accept", 32'(last_cyc - t), 32'd1);
    req_v    = 1'b1;
    req_we   = 1'b1;
    req_addr = 14'h0108;
    req_size = 2'd2;
    req_data = 32'h3333_3333;
    @(negedge clk);
    checkOutput("t5_full_ready", 32'(req_ready), 32'd0);
    next_slot();
    @(negedge clk);
    checkOutput("t5_full_ready2", 32'(req_ready), 32'd0);
    pop_credits = 1;
    next_slot();
    applyStimulus(1'b1, 14'h0108, 2'd2, 32'h3333_3333, 0, 32'h0);
    checkOutput("t5_reopen", 32'(last_cyc - t), 32'd5);
    yumi_mode = 1;
    repeat (4) next_slot();

    // Reset while a read is pending.
    applyStimulus(1'b0, 14'h0200, 2'd2, 32'h0, 0, 32'h0);
    next_slot();
    reset_n = 1'b0;
    #1;
    checkOutput("t6_ready", 32'(req_ready), 32'd0);
    checkOutput("t6_resp_v", 32'(resp_v), 32'd0);
    checkOutput("t6_ren", 32'(read_en), 32'd0);
    checkOutput("t6_wen", 32'(write_en), 32'd0);
    checkOutput("t6_addr", 32'(addr_o), 32'd0);
    checkOutput("t6_wdata", write_data, 32'd0);
    checkOutput("t6_stray", 32'(stray), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    next_slot();
    applyStimulus(1'b0, 14'h0300, 2'd2, 32'h0, 1, 32'hCAFE_F00D);
    @(negedge clk);
    checkOutput("t6_no_stale", 32'(resp_v), 32'd0);
    @(negedge clk);
    checkOutput("t6_resp_v", 32'(resp_v), 32'd1);
    checkOutput("t6_resp_data", resp_data, 32'hCAFE_F00D);
    @(negedge clk);
    checkOutput("t6_single_resp", 32'(resp_v), 32'd0);
    wait_ctrl();
    next_slot();

    // Randomized traffic against the model.
    yumi_mode = 0;
    for (int n = 0; n < 300; n++) begin
      sz = int'($urandom_range(0, 3));
      a  = 14'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        mask = (1 << sz) - 1;
        a    = a & ~14'(mask);
      end
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       dly = int'($urandom_range(1, 4));
      else if (sel == 7) dly = 15;
      else if (sel == 8) dly = ($urandom_range(0, 1) != 0) ? 14 : 16;
      else               dly = 18;
      t2 = int'($urandom_range(0, 1));
      applyStimulus(t2 != 0, a, 2'(sz), $urandom, dly, $urandom);
      if (t2 == 0) wait_ctrl();
      repeat ($urandom_range(0, 2)) next_slot();
    end

    yumi_mode = 1;
    repeat (6) next_slot();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    miscompares++;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
